// File: rtl/nonce_sequencer.sv
// nonce_sequencer
//   Upstream control stage for the block concatenator. It latches a 12-byte
//   entry word and sweeps a nonce from NONCE_START to MAX_NONCE. Each
//   entry+nonce pair is presented with a one-cycle selector strobe. After
//   each strobe the block waits for the hash stage's verdict. The sweep stops
//   on a match, when the nonce space is exhausted, or when abort is asserted.
//
// Optional feature macro: NONCE_SEQ_TIMEOUT_EN
//   When defined, a watchdog counts cycles spent in WAIT. After TIMEOUT_CYC
//   cycles without hash_done, the same nonce is re-issued and timeout pulses
//   for one cycle. When undefined, timeout is constant 0 and WAIT waits
//   indefinitely.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-low
//   start        one-cycle request: latch entry_in and begin a sweep
//   abort        terminate the sweep and return to IDLE
//   entry_in     12-byte entry, byte k = bits [8k+7:8k]
//   hash_done    verdict valid for the block last issued
//   hash_match   verdict (1 = meets target), qualified by hash_done
//   entry_12     latched entry presented to the concatenator
//   nonce        current nonce presented to the concatenator
//   selector     one-cycle strobe: entry_12/nonce are valid this cycle
//   busy         sweep in progress (ISSUE or WAIT)
//   found        sticky: a match was reported
//   exhausted    sticky: MAX_NONCE was tried without a match
//   nonce_found  nonce that produced the match
//   timeout      one-cycle pulse on a watchdog retry
module nonce_sequencer #(
  parameter int                 NONCE_W     = 32,
  parameter logic [NONCE_W-1:0] NONCE_START = '0,
  parameter logic [NONCE_W-1:0] MAX_NONCE   = '1,
  parameter int                 TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [95:0]        entry_in,
  input  logic               hash_done,
  input  logic               hash_match,
  output logic [95:0]        entry_12,
  output logic [NONCE_W-1:0] nonce,
  output logic               selector,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic [NONCE_W-1:0] nonce_found,
  output logic               timeout
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t state, next_state;
  logic   do_load, do_inc, do_found, do_exh, do_retry;
  logic   tmo_expire;

`ifdef NONCE_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] wait_cnt;

  // The counter restarts every time WAIT is entered, because any other
  // state forces it to zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state == S_WAIT) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign tmo_expire = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign tmo_expire = 1'b0;
`endif

  // Next state and action decode; priority is abort > hash_done > start.
  always_comb begin
    next_state = state;
    do_load    = 1'b0;
    do_inc     = 1'b0;
    do_found   = 1'b0;
    do_exh     = 1'b0;
    do_retry   = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (start) begin
          next_state = S_ISSUE;
          do_load    = 1'b1;
        end
      end
      S_ISSUE: begin
        next_state = abort ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (abort) begin
          next_state = S_IDLE;
        end else if (hash_done) begin
          if (hash_match) begin
            next_state = S_DONE;
            do_found   = 1'b1;
          // ">=" also covers NONCE_START > MAX_NONCE (single attempt).
          // It also stops the nonce from wrapping past MAX_NONCE.
          end else if (nonce >= MAX_NONCE) begin
            next_state = S_DONE;
            do_exh     = 1'b1;
          end else begin
            next_state = S_ISSUE;
            do_inc     = 1'b1;
          end
        end else if (tmo_expire) begin
          next_state = S_ISSUE;
          do_retry   = 1'b1;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // All outputs are registered from the decoded next state and actions.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      entry_12    <= '0;
      nonce       <= '0;
      selector    <= 1'b0;
      busy        <= 1'b0;
      found       <= 1'b0;
      exhausted   <= 1'b0;
      nonce_found <= '0;
      timeout     <= 1'b0;
    end else begin
      state    <= next_state;
      selector <= (next_state == S_ISSUE);
      busy     <= (next_state == S_ISSUE) || (next_state == S_WAIT);
      timeout  <= do_retry;
      if (do_load) begin
        entry_12  <= entry_in;
        nonce     <= NONCE_START;
        found     <= 1'b0;
        exhausted <= 1'b0;
      end
      if (do_inc) begin
        nonce <= nonce + 1'b1;
      end
      if (do_found) begin
        found       <= 1'b1;
        nonce_found <= nonce;
      end
      if (do_exh) begin
        exhausted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_nonce_sequencer.sv
module tb_nonce_sequencer;

`ifdef NONCE_SEQ_TIMEOUT_EN
  localparam logic TMO_EXP = 1'b1;
`else
  localparam logic TMO_EXP = 1'b0;
`endif

  localparam logic [95:0] E  = 96'h0B0A_0908_0706_0504_0302_0100;
  localparam logic [95:0] E2 = 96'h1111_2222_3333_4444_5555_6666;
  localparam logic [95:0] NX = 96'hDEAD_BEEF_CAFE_F00D_1234_5678;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, abort, hash_done, hash_match;
  logic [95:0] entry_in;

  logic [95:0] entry_12, ex_entry_12;
  logic [31:0] nonce, nonce_found, ex_nonce, ex_nonce_found;
  logic        selector, busy, found, exhausted, timeout;
  logic        ex_selector, ex_busy, ex_found, ex_exhausted, ex_timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nonce_sequencer #(
    .NONCE_W(32), .NONCE_START(32'h0), .MAX_NONCE(32'hFFFF_FFFF), .TIMEOUT_CYC(4)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .entry_in(entry_in),
    .hash_done(hash_done), .hash_match(hash_match), .entry_12(entry_12),
    .nonce(nonce), .selector(selector), .busy(busy), .found(found),
    .exhausted(exhausted), .nonce_found(nonce_found), .timeout(timeout)
  );

  nonce_sequencer #(
    .NONCE_W(32), .NONCE_START(32'hFFFF_FFFE), .MAX_NONCE(32'hFFFF_FFFF), .TIMEOUT_CYC(4)
  ) dut_ex (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .entry_in(entry_in),
    .hash_done(hash_done), .hash_match(hash_match), .entry_12(ex_entry_12),
    .nonce(ex_nonce), .selector(ex_selector), .busy(ex_busy), .found(ex_found),
    .exhausted(ex_exhausted), .nonce_found(ex_nonce_found), .timeout(ex_timeout)
  );

  typedef struct {
    logic        st, ab, hd, hm;
    logic [95:0] ent;
    logic        sel, bsy, fnd, exh;
    logic [31:0] nn, nf;
    logic [95:0] e12;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic st, ab, hd, hm, input logic [95:0] ent,
                              input logic sel, bsy, fnd, exh,
                              input logic [31:0] nn, nf, input logic [95:0] e12);
    vec_t v;
    v.st = st; v.ab = ab; v.hd = hd; v.hm = hm; v.ent = ent;
    v.sel = sel; v.bsy = bsy; v.fnd = fnd; v.exh = exh;
    v.nn = nn; v.nf = nf; v.e12 = e12;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic st, ab, hd, hm, input logic [95:0] ent);
    start = st; abort = ab; hash_done = hd; hash_match = hm; entry_in = ent;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_entry"}, entry_12, '0);
    chk({tag, "_nonce"}, {64'h0, nonce}, '0);
    chk({tag, "_flags"}, {selector, busy, found, exhausted, timeout}, '0);
    chk({tag, "_nonce_found"}, {64'h0, nonce_found}, '0);
  endtask

  int sel_cnt;

  initial begin
    // Table: {start, abort, hash_done, hash_match, entry_in} -> expected
    // {selector, busy, found, exhausted, nonce, nonce_found, entry_12}.
    add(1,0,0,0,E,   1,1,0,0, 0,0,E);   // 0 start -> first issue
    add(0,0,0,0,NX,  0,1,0,0, 0,0,E);   // 1 WAIT
    add(0,0,1,0,NX,  1,1,0,0, 1,0,E);   // 2 miss nonce 0
    add(0,0,0,0,NX,  0,1,0,0, 1,0,E);   // 3
    add(0,0,1,0,NX,  1,1,0,0, 2,0,E);   // 4 miss nonce 1
    add(0,0,0,0,NX,  0,1,0,0, 2,0,E);   // 5
    add(1,0,0,0,NX,  0,1,0,0, 2,0,E);   // 6 start mid-sweep ignored
    add(0,0,1,0,NX,  1,1,0,0, 3,0,E);   // 7 miss nonce 2
    add(0,0,1,1,NX,  0,1,0,0, 3,0,E);   // 8 verdict during ISSUE ignored
    add(0,0,0,1,NX,  0,1,0,0, 3,0,E);   // 9 match without done ignored
    add(0,0,1,1,NX,  0,0,1,0, 3,3,E);   // 10 match nonce 3
    add(0,0,0,0,NX,  0,0,1,0, 3,3,E);   // 11 DONE holds
    add(1,0,0,0,E2,  1,1,0,0, 0,3,E2);  // 12 restart from DONE
    add(0,0,0,0,NX,  0,1,0,0, 0,3,E2);  // 13
    add(0,1,1,1,NX,  0,0,0,0, 0,3,E2);  // 14 abort beats match
    add(0,0,0,0,NX,  0,0,0,0, 0,3,E2);  // 15 IDLE
    add(1,0,0,0,E,   1,1,0,0, 0,3,E);   // 16 restart at NONCE_START
    add(0,0,0,0,NX,  0,1,0,0, 0,3,E);   // 17
    add(0,0,1,0,NX,  1,1,0,0, 1,3,E);   // 18
    add(0,0,0,0,NX,  0,1,0,0, 1,3,E);   // 19
    add(0,1,0,0,NX,  0,0,0,0, 1,3,E);   // 20 abort in WAIT

    // Reset held for three cycles.
    reset = 1'b0;
    drive(0,0,0,0,NX);
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b1;
    step();
    chk("idle_selector", {95'h0, selector}, 96'h0);

    sel_cnt = 0;
    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].ab, tbl[i].hd, tbl[i].hm, tbl[i].ent);
      step();
      if (selector === 1'b1 && i <= 11) sel_cnt++;
      chk($sformatf("row%0d_selector", i), {95'h0, selector}, {95'h0, tbl[i].sel});
      chk($sformatf("row%0d_busy", i), {95'h0, busy}, {95'h0, tbl[i].bsy});
      chk($sformatf("row%0d_found", i), {95'h0, found}, {95'h0, tbl[i].fnd});
      chk($sformatf("row%0d_exhausted", i), {95'h0, exhausted}, {95'h0, tbl[i].exh});
      chk($sformatf("row%0d_nonce", i), {64'h0, nonce}, {64'h0, tbl[i].nn});
      chk($sformatf("row%0d_nonce_found", i), {64'h0, nonce_found}, {64'h0, tbl[i].nf});
      chk($sformatf("row%0d_entry", i), entry_12, tbl[i].e12);
      chk($sformatf("row%0d_timeout", i), {95'h0, timeout}, 96'h0);
    end
    chk("match_sweep_selector_pulses", 96'(sel_cnt), 96'd4);

    // Watchdog: withhold hash_done after the first issue.
    drive(1,0,0,0,E);
    step();
    chk("tmo_first_issue", {94'h0, selector, timeout}, {94'h0, 1'b1, 1'b0});
    drive(0,0,0,0,NX);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk($sformatf("tmo_wait%0d", k), {94'h0, selector, timeout}, 96'h0);
    end
    step();
    chk("tmo_expire_timeout", {95'h0, timeout}, {95'h0, TMO_EXP});
    chk("tmo_expire_selector", {95'h0, selector}, {95'h0, TMO_EXP});
    chk("tmo_expire_nonce", {64'h0, nonce}, 96'h0);
    chk("tmo_expire_busy", {95'h0, busy}, 96'h1);
    step();
    chk("tmo_after", {94'h0, selector, timeout}, 96'h0);
    repeat (3) step();
    // The verdict arrives on the cycle the watchdog would expire again.
    drive(0,0,1,0,NX);
    step();
    chk("tmo_tie_selector", {95'h0, selector}, 96'h1);
    chk("tmo_tie_timeout", {95'h0, timeout}, 96'h0);
    chk("tmo_tie_nonce", {64'h0, nonce}, 96'h1);

    // Reset mid-sweep clears everything on the next edge.
    drive(0,0,1,1,NX);
    reset = 1'b0;
    step();
    chk_all_zero("midreset");

    // Exhaustion on the high-start instance.
    drive(0,0,0,0,NX);
    reset = 1'b1;
    step();
    sel_cnt = 0;
    drive(1,0,0,0,E);
    step();
    if (ex_selector === 1'b1) sel_cnt++;
    chk("exh_first_nonce", {64'h0, ex_nonce}, {64'h0, 32'hFFFF_FFFE});
    chk("exh_first_sel", {95'h0, ex_selector}, 96'h1);
    drive(0,0,0,0,NX);
    step();
    drive(0,0,1,0,NX);
    step();
    if (ex_selector === 1'b1) sel_cnt++;
    chk("exh_second_nonce", {64'h0, ex_nonce}, {64'h0, 32'hFFFF_FFFF});
    chk("exh_second_flag", {95'h0, ex_exhausted}, 96'h0);
    drive(0,0,0,0,NX);
    step();
    drive(0,0,1,0,NX);
    step();
    chk("exh_flag", {95'h0, ex_exhausted}, 96'h1);
    chk("exh_busy", {94'h0, ex_busy, ex_found}, 96'h0);
    chk("exh_nonce_hold", {64'h0, ex_nonce}, {64'h0, 32'hFFFF_FFFF});
    drive(0,0,0,0,NX);
    step();
    chk("exh_no_wrap", {64'h0, ex_nonce}, {64'h0, 32'hFFFF_FFFF});
    chk("exh_sticky", {94'h0, ex_exhausted, ex_selector}, {94'h0, 1'b1, 1'b0});
    chk("exh_selector_pulses", 96'(sel_cnt), 96'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
